// File: rtl/spc_spi_write_register.sv
// SPI-slave write register: shifts a command byte plus N_BYTES payload bytes in LSB first
// while cs_n is low, and commits the payload to `out` when cs_n rises after a well-formed WRITE frame.
module spc_spi_write_register #(
  parameter int          N_BYTES     = 2,
  parameter int          OUTPUT_BITS = 8 * N_BYTES,
  parameter logic [7:0]  CMD_WRITE   = 8'h91
) (
  input  logic                   sclk,
  input  logic                   rst_n,
  input  logic                   mosi,
  input  logic                   cs_n,
  output logic [OUTPUT_BITS-1:0] out,
  output logic                   data_ready
);

  localparam int FRAME_BITS = 8 * (N_BYTES + 1);
  localparam int CNT_W      = $clog2(FRAME_BITS + 2);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0] OVER_CNT = CNT_W'(FRAME_BITS + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // The frame phase is fully implied by cs_n and the bit counter.
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_FULL,
    ST_OVER
  } state_t;

  state_t                 state;
  logic [FRAME_BITS-1:0]  sr_reg, sr_next;
  logic [CNT_W-1:0]       cnt_reg, cnt_next;
  logic [OUTPUT_BITS-1:0] out_reg, out_next;
  logic                   data_ready_reg, data_ready_next;
  logic [7:0]             cmd;
  logic [OUTPUT_BITS-1:0] payload;

  assign cmd = sr_reg[7:0];

  // Payload byte k lands in out[8k+7:8k]; LSB-first shifting already places bit i at 8k+i.
  generate
    for (genvar gi = 0; gi < N_BYTES; gi++) begin : g_payload
      assign payload[8*gi +: 8] = sr_reg[8*(gi+1) +: 8];
    end
  endgenerate

  always_comb begin
    state = ST_IDLE;
    if (!cs_n) begin
      if (cnt_reg < FULL_CNT)
        state = ST_SHIFT;
      else if (cnt_reg == FULL_CNT)
        state = ST_FULL;
      else
        state = ST_OVER;
    end
  end

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      sr_reg         <= '0;
      cnt_reg        <= '0;
      out_reg        <= '0;
      data_ready_reg <= 1'b0;
    end else begin
      sr_reg         <= sr_next;
      cnt_reg        <= cnt_next;
      out_reg        <= out_next;
      data_ready_reg <= data_ready_next;
    end
  end

  always_comb begin
    sr_next         = sr_reg;
    cnt_next        = cnt_reg;
    out_next        = out_reg;
    data_ready_next = 1'b0;
    case (state)
      ST_IDLE: begin
        // Only an exactly full frame carrying the WRITE command commits.
        cnt_next = '0;
        if (cnt_reg == FULL_CNT && cmd == CMD_WRITE) begin
          out_next        = payload;
          data_ready_next = 1'b1;
        end
      end
      ST_SHIFT, ST_FULL: begin
        sr_next  = {mosi, sr_reg[FRAME_BITS-1:1]};
        cnt_next = cnt_reg + CNT_ONE;
      end
      ST_OVER: begin
        // Saturate so an over-long frame can never wrap back to FULL.
        sr_next  = {mosi, sr_reg[FRAME_BITS-1:1]};
        cnt_next = OVER_CNT;
      end
      default: begin
        cnt_next = '0;
      end
    endcase
  end

  assign out        = out_reg;
  assign data_ready = data_ready_reg;

endmodule

// File: tb/tb_spc_spi_write_register.sv
// Directed bench for spc_spi_write_register: table of framed writes plus a mid-frame reset sequence.
module tb_spc_spi_write_register;

  logic        sclk;
  logic        rst_n;
  logic        mosi;
  logic        cs_n;
  logic [15:0] out;
  logic        data_ready;

  int checks = 0;
  int errors = 0;
  int pulse_cnt = 0;

  spc_spi_write_register dut (
    .sclk      (sclk),
    .rst_n     (rst_n),
    .mosi      (mosi),
    .cs_n      (cs_n),
    .out       (out),
    .data_ready(data_ready)
  );

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  always @(negedge sclk) if (data_ready) pulse_cnt++;

  typedef struct {
    logic [31:0] frame;
    int          nbits;
    logic [15:0] exp_out;
    int          exp_pulses;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive nbits of frame LSB first on falling edges, then raise cs_n.
  task automatic send_bits(input logic [31:0] frame, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      @(negedge sclk);
      cs_n = 1'b0;
      mosi = frame[i];
    end
    @(negedge sclk);
    cs_n = 1'b1;
    mosi = 1'b0;
  endtask

  // After cs_n rises: commit edge, then check out/data_ready, then the pulse has ended.
  task automatic finish_frame(input string tag, input logic [15:0] exp_out, input int exp_pulses,
                              input int pulses_before);
    @(negedge sclk);
    #1;
    check({tag, " out"}, {16'h0, out}, {16'h0, exp_out});
    check({tag, " data_ready"}, {31'h0, data_ready}, (exp_pulses != 0) ? 32'd1 : 32'd0);
    @(negedge sclk);
    #1;
    check({tag, " pulse_end"}, {31'h0, data_ready}, 32'd0);
    check({tag, " pulses"}, pulse_cnt - pulses_before, exp_pulses);
    $display("frame %s: out=%h pulses=%0d", tag, out, pulse_cnt - pulses_before);
  endtask

  initial begin
    int p0;
    logic [31:0] f;

    vecs[0] = '{32'h00FFFF91, 24, 16'hFFFF, 1};
    vecs[1] = '{32'h00000091, 24, 16'h0000, 1};
    vecs[2] = '{32'h00555591, 24, 16'h5555, 1};
    vecs[3] = '{32'h00123491, 24, 16'h1234, 1};
    vecs[4] = '{32'h00AAAA90, 24, 16'h1234, 0};
    vecs[5] = '{32'h00FFFF91, 23, 16'h1234, 0};
    vecs[6] = '{32'h01FFFF91, 25, 16'h1234, 0};

    rst_n = 1'b0;
    cs_n  = 1'b1;
    mosi  = 1'b0;
    repeat (3) @(negedge sclk);
    #1;
    check("reset out", {16'h0, out}, 32'h0);
    check("reset data_ready", {31'h0, data_ready}, 32'h0);
    rst_n = 1'b1;
    repeat (4) @(negedge sclk);
    #1;
    check("idle out", {16'h0, out}, 32'h0);
    check("idle data_ready", {31'h0, data_ready}, 32'h0);
    $display("reset: out=%h data_ready=%b", out, data_ready);

    for (int v = 0; v < 7; v++) begin
      p0 = pulse_cnt;
      send_bits(vecs[v].frame, vecs[v].nbits);
      finish_frame($sformatf("vec%0d", v), vecs[v].exp_out, vecs[v].exp_pulses, p0);
    end

    // Reset after 12 bits: out clears at once, the tail of the frame must not commit.
    p0 = pulse_cnt;
    f  = 32'h00FFFF91;
    for (int i = 0; i < 24; i++) begin
      @(negedge sclk);
      cs_n = 1'b0;
      mosi = f[i];
      if (i == 12) begin
        rst_n = 1'b0;
        #1;
        check("midreset out", {16'h0, out}, 32'h0);
        check("midreset data_ready", {31'h0, data_ready}, 32'h0);
      end else if (i == 13) begin
        rst_n = 1'b1;
      end
    end
    @(negedge sclk);
    cs_n = 1'b1;
    mosi = 1'b0;
    finish_frame("after_reset_tail", 16'h0000, 0, p0);

    p0 = pulse_cnt;
    send_bits(32'h00555591, 24);
    finish_frame("post_reset_valid", 16'h5555, 1, p0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/spc_spi_write_register.md
# spc_spi_write_register

SPI-slave write register (module `spc`, serial-to-parallel converter): receives a framed serial write on `mosi` under `cs_n` and presents the payload on a parallel output that holds until the next valid write. It sits at the chip boundary behind an external SPI master and drives static configuration bits into the core. Only one command, WRITE, is implemented; every other frame is discarded.

## Interface
- `N_BYTES`, default 2: payload length in bytes.
- `OUTPUT_BITS`, default `8*N_BYTES`: width of `out`, derived.
- `CMD_WRITE`, default 8'h91 (8'b1001_0001): command byte that enables a commit.
- Clocking and reset: one clock; reset is asynchronous and active-low.
- `sclk`  input  1  SPI clock; the only clock. All logic on rising edge. Must keep toggling while `cs_n` is high so a frame can commit.
- `rst_n`  input  1  asynchronous active-low reset.
- `mosi`  input  1  serial data, sampled on rising `sclk`.
- `cs_n`  input  1  active-low frame select, sampled on rising `sclk`.
- `out`  output  OUTPUT_BITS  committed payload register.
- `data_ready`  output  1  one-`sclk`-cycle pulse when `out` is updated.

## Operation
- Frame = `FRAME_BITS` = 8*(N_BYTES+1) bits: one command byte, then N_BYTES payload bytes.
- Bit order is LSB first within each byte. Bytes are in order: command, then payload byte 0, byte 1, ...
- Payload byte k maps to `out[8k+7:8k]`, with its bit i at `out[8k+i]`. Default: `out = {byte1, byte0}`.
- Shift register `sr` is FRAME_BITS wide. On each rising `sclk` with `cs_n`=0:
  - `sr <= {mosi, sr[FRAME_BITS-1:1]}`.
  - Bit counter increments, saturating at FRAME_BITS+1.
  - At frame end, `sr[7:0]` holds the command and `sr[FRAME_BITS-1:8]` holds the payload.
- On each rising `sclk` with `cs_n`=1:
  - If count == FRAME_BITS and `sr[7:0]` == CMD_WRITE: `out <= sr[FRAME_BITS-1:8]` and `data_ready <= 1`.
  - Otherwise: `out` holds and `data_ready <= 0`.
  - In both cases the counter clears to 0.
- States are implicit in the counter:
  - IDLE: `cs_n` high.
  - SHIFT: count < FRAME_BITS.
  - FULL: count == FRAME_BITS.
  - OVER: count == FRAME_BITS+1.
  - Only FULL commits when `cs_n` rises.
- Discard cases (`out` unchanged, no pulse):
  - Short frame (fewer than FRAME_BITS bits).
  - Long frame (more than FRAME_BITS bits).
  - Command byte other than CMD_WRITE.
- A glitch where `cs_n` goes high and then low again between two rising edges is not seen and is not required to be handled.

## Timing
- Reset (asynchronous, `rst_n`=0):
  - `out` = 0, `data_ready` = 0.
  - Counter = 0, `sr` = 0.
- Reset mid-frame aborts the frame. The next frame must start from a fresh `cs_n` falling edge.
- Master protocol: change `mosi`/`cs_n` on falling `sclk`; the DUT samples them on rising `sclk`.
- The first data bit must be valid at the first rising edge where `cs_n`=0.
- Latency:
  - `out` updates at the first rising `sclk` where `cs_n` is sampled high after a complete valid frame.
  - It is therefore stable at the next falling edge, one cycle after `cs_n` deasserts.
- `data_ready` is high for exactly one `sclk` cycle, coincident with the `out` update.
- Back-to-back frames need at least one rising edge with `cs_n` high between them. That edge performs the commit and clears the counter.

## Test plan
- Reset, then no frame -> `out`=16'h0000, `data_ready`=0.
- Frame {91, FF, FF} LSB first, `cs_n` raised after bit 24 -> at the next falling edge `out`=16'hFFFF and `data_ready` has pulsed once.
- Then frame {91, 00, 00} -> `out`=16'h0000. Then frame {91, 55, 55} -> `out`=16'h5555.
- Asymmetric frame {91, 34, 12} -> `out`=16'h1234, confirming byte and bit order.
- Each of the following leaves `out` at its prior value (16'h1234) with no `data_ready` pulse:
  - Wrong command {90, AA, AA}.
  - 23-bit frame.
  - 25-bit frame.
- `rst_n` asserted mid-frame after 12 bits of {91, FF, FF} -> `out`=16'h0000 immediately. The remaining bits with `cs_n` still low are ignored at commit, since count != 24 is accumulated only after a fresh start. The following valid frame {91, 55, 55} -> `out`=16'h5555.
